// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_VW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, compare, and
// conditionally subtract the divisor.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   rem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_out,
  output logic          q_bit
);

  logic [VW:0] shifted;

  // The extra top bit keeps the shifted value from wrapping before the compare.
  always_comb begin
    shifted = (rem_in << 1) | {{VW{1'b0}}, bit_in};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? (shifted - {1'b0, divisor}) : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider: one quotient bit per clock, MSB first, with
// results published only when the operation completes.
module seq_divider
  import div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

  state_e        state, state_nxt;
  logic [DW-1:0] work;
  logic [VW-1:0] dvs;
  logic [VW:0]   prem, prem_nxt;
  logic [CW-1:0] cnt;
  logic          q_bit;
  logic          accept;
  logic          last_step;

  assign accept    = start && (state != CALC);
  assign last_step = (state == CALC) && (cnt == CW'(1));

  div_step #(.VW(VW)) u_step (
    .rem_in  (prem),
    .bit_in  (work[DW-1]),
    .divisor (dvs),
    .rem_out (prem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = (divisor == '0) ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      work        <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_by_zero <= (divisor == '0);
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= '0;
      end else begin
        work <= dividend;
        dvs  <= divisor;
        prem <= '0;
        cnt  <= CW'(DW);
      end
    end else if (state == CALC) begin
      // The dividend register doubles as the quotient accumulator: bits shift
      // out at the top as quotient bits shift in at the bottom.
      work <= {work[DW-2:0], q_bit};
      prem <= prem_nxt;
      cnt  <= cnt - CW'(1);
      if (last_step) begin
        quotient  <= {work[DW-2:0], q_bit};
        remainder <= prem_nxt[VW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          busy;
  logic          done;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic void model(input int a, input int b, output logic [DW-1:0] q,
                                output logic [VW-1:0] r, output logic z, output int lat);
    if (b == 0) begin
      q = '1; r = '0; z = 1'b1; lat = 1;
    end else begin
      q = DW'(a / b); r = VW'(a % b); z = 1'b0; lat = DW + 1;
    end
  endfunction

  // Starts one operation from a negedge and returns at the negedge of the done
  // cycle (or after a bounded wait). lat counts cycles from the accepting edge.
  task automatic do_op(input logic [DW-1:0] a, input logic [VW-1:0] b, output int lat,
                       output int busy_n, output bit overlap, output bit hold_bad);
    logic [DW-1:0] q0;
    logic [VW-1:0] r0;
    lat = 0; busy_n = 0; overlap = 1'b0; hold_bad = 1'b0;
    q0 = quotient; r0 = remainder;
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    forever begin
      if (busy && done) overlap = 1'b1;
      if (done || lat >= 40) break;
      if (quotient !== q0 || remainder !== r0) hold_bad = 1'b1;
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got q=%0d r=%0d busy=%b done=%b dbz=%b want all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bn; bit ov, hb;
    do_op(8'd200, 4'd7, lat, bn, ov, hb);
    checks++;
    if (bn !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", bn); end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL basic_done_latency got %0d want 9", lat); end
    checks++;
    if (quotient !== 8'd28 || remainder !== 4'd4 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got q=%0d r=%0d dbz=%b want q=28 r=4 dbz=0",
               quotient, remainder, div_by_zero);
    end
    checks++;
    if (ov || hb) begin errors++; $display("FAIL basic_overlap_or_hold got ov=%b hold=%b want 0 0", ov, hb); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || quotient !== 8'd28 || remainder !== 4'd4) begin
      errors++;
      $display("FAIL basic_after_done got done=%b q=%0d r=%0d want done=0 q=28 r=4", done, quotient, remainder);
    end
  endtask

  task automatic test_corners();
    logic [DW-1:0] a [3] = '{8'd255, 8'd255, 8'd0};
    logic [VW-1:0] b [3] = '{4'd15, 4'd1, 4'd5};
    logic [DW-1:0] eq [3] = '{8'd17, 8'd255, 8'd0};
    int lat, bn; bit ov, hb;
    for (int i = 0; i < 3; i++) begin
      do_op(a[i], b[i], lat, bn, ov, hb);
      checks++;
      if (quotient !== eq[i] || remainder !== 4'd0 || lat !== 9 || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL corner_%0d/%0d got q=%0d r=%0d lat=%0d dbz=%b want q=%0d r=0 lat=9 dbz=0",
                 a[i], b[i], quotient, remainder, lat, div_by_zero, eq[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int lat, bn; bit ov, hb;
    do_op(8'd13, 4'd0, lat, bn, ov, hb);
    checks++;
    if (lat !== 1 || bn !== 0) begin
      errors++;
      $display("FAIL dbz_timing got lat=%0d busy_cycles=%0d want lat=1 busy_cycles=0", lat, bn);
    end
    checks++;
    if (quotient !== 8'hFF || remainder !== 4'd0 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dbz_result got q=%0h r=%0d dbz=%b want q=ff r=0 dbz=1", quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || div_by_zero !== 1'b1 || quotient !== 8'hFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL dbz_hold got done=%b dbz=%b q=%0h busy=%b want done=0 dbz=1 q=ff busy=0",
               done, div_by_zero, quotient, busy);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    dividend = 8'd100; divisor = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    lat = 4;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL ignore_latency got %0d want 9", lat); end
    checks++;
    if (quotient !== 8'd11 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result got q=%0d r=%0d dbz=%b want q=11 r=1 dbz=0", quotient, remainder, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat, bn; bit ov, hb, saw_done;
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL abort_outputs got q=%0d r=%0d busy=%b done=%b dbz=%b want all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL abort_no_done got activity=1 want 0"); end
    do_op(8'd9, 4'd2, lat, bn, ov, hb);
    checks++;
    if (quotient !== 8'd4 || remainder !== 4'd1 || lat !== 9) begin
      errors++;
      $display("FAIL abort_followup got q=%0d r=%0d lat=%0d want q=4 r=1 lat=9", quotient, remainder, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [DW-1:0] a [N];
    logic [VW-1:0] b [N];
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic          ez;
    int el, k, cyc, last;
    for (int i = 0; i < N; i++) begin
      a[i] = DW'($urandom_range(255, 0));
      b[i] = VW'($urandom_range(15, 1));
    end
    k = 0; cyc = 0; last = -1;
    dividend = a[0]; divisor = b[0]; start = 1'b1;
    while (k < N && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        model(int'(a[k]), int'(b[k]), eq, er, ez, el);
        checks++;
        if (quotient !== eq || remainder !== er || div_by_zero !== ez || busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result %0d/%0d got q=%0d r=%0d dbz=%b busy=%b want q=%0d r=%0d dbz=%b busy=0",
                   a[k], b[k], quotient, remainder, div_by_zero, busy, eq, er, ez);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last !== DW + 1) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want %0d", cyc - last, DW + 1);
          end
        end
        last = cyc;
        k++;
        if (k < N) begin dividend = a[k]; divisor = b[k]; end
        else start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (k !== N) begin errors++; $display("FAIL b2b_completed got %0d want %0d", k, N); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_sweep();
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic          ez;
    int el, lat, bn, ebn, shown;
    bit ov, hb;
    shown = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(DW'(a), VW'(b), lat, bn, ov, hb);
        model(a, b, eq, er, ez, el);
        ebn = (b == 0) ? 0 : DW;
        checks++;
        if (quotient !== eq || remainder !== er || div_by_zero !== ez || lat !== el ||
            bn !== ebn || ov || hb) begin
          errors++;
          if (shown < 10) begin
            shown++;
            $display("FAIL sweep_%0d/%0d got q=%0d r=%0d dbz=%b lat=%0d busy=%0d ov=%b hold=%b want q=%0d r=%0d dbz=%b lat=%0d busy=%0d",
                     a, b, quotient, remainder, div_by_zero, lat, bn, ov, hb, eq, er, ez, el, ebn);
          end
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
